// File: rtl/sram_cache_controller.sv
// sram_cache_controller: 2-way set-associative write-through read cache in front of the SRAM controller.
module sram_cache_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        freeze,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);
  typedef enum logic [1:0] {IDLE, RMISS, WRITE} state_t;
  state_t state, state_nx;
  logic [63:0] valid0, valid1, lru;
  logic [9:0]  tag0 [64];
  logic [9:0]  tag1 [64];
  logic [63:0] data0 [64];
  logic [63:0] data1 [64];
  logic [5:0]  idx;
  logic [9:0]  tg;
  logic        ws, hit0, hit1, hit, fill, rd_hit, wr_hit;
  logic [63:0] hit_line;
  assign idx = address[8:3];
  assign tg  = address[18:9];
  assign ws  = address[2];
  always_comb begin
    hit0 = valid0[idx] & (tag0[idx] == tg);
    hit1 = valid1[idx] & (tag1[idx] == tg);
    hit = hit0 | hit1;
    hit_line = hit0 ? data0[idx] : data1[idx];
    fill = (state == RMISS) & sram_ready;
    rd_hit = (state == IDLE) & rd_en & ~wr_en & hit;
    wr_hit = (state == WRITE) & hit;
    state_nx = (state == IDLE) ? (wr_en ? WRITE : (rd_en & ~hit) ? RMISS : IDLE)
             : sram_ready ? IDLE : state;
    sram_rd_en = (state == RMISS) | ((state == IDLE) & rd_en & ~wr_en & ~hit);
    sram_wr_en = (state == WRITE) | ((state == IDLE) & wr_en);
    freeze = (rd_en & ~hit & ~sram_ready) | (wr_en & ~sram_ready);
    rdata = (rd_en & hit) ? (ws ? hit_line[63:32] : hit_line[31:0])
          : fill ? (ws ? sram_rdata[63:32] : sram_rdata[31:0]) : 32'h0;
    sram_address = wr_en ? address : {address[31:3], 1'b0, address[1:0]};
    sram_wdata = wdata;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      valid0 <= '0;
      valid1 <= '0;
      lru <= '0;
    end else begin
      state <= state_nx;
      if (fill) begin
        if (lru[idx]) valid1[idx] <= 1'b1;
        else valid0[idx] <= 1'b1;
        lru[idx] <= ~lru[idx];
      end else if (rd_hit) begin
        lru[idx] <= hit0;
      end
    end
  end
  // Payload arrays need no reset: fill only happens in RMISS, which reset leaves immediately.
  always_ff @(posedge clk) begin
    if (fill) begin
      if (lru[idx]) begin
        tag1[idx] <= tg;
        data1[idx] <= sram_rdata;
      end else begin
        tag0[idx] <= tg;
        data0[idx] <= sram_rdata;
      end
    end else if (wr_hit) begin
      if (hit0) data0[idx] <= ws ? {wdata, data0[idx][31:0]} : {data0[idx][63:32], wdata};
      else data1[idx] <= ws ? {wdata, data1[idx][31:0]} : {data1[idx][63:32], wdata};
    end
  end
endmodule

// File: tb/tb_sram_cache_controller.sv
// tb_sram_cache_controller: directed tests of hits, fills, LRU replacement, write-through and reset.
module tb_sram_cache_controller;
  logic        clk = 0, rst = 0, rd_en = 0, wr_en = 0, sram_ready = 0;
  logic [31:0] address = 0, wdata = 0;
  logic [63:0] sram_rdata = 0;
  logic [31:0] rdata, sram_address, sram_wdata;
  logic        freeze, sram_rd_en, sram_wr_en;
  int checks = 0, errors = 0;
  logic        miss, bad, fz;
  logic [31:0] data;

  sram_cache_controller dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address), .wdata(wdata),
    .rdata(rdata), .freeze(freeze), .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
    .sram_address(sram_address), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ready(sram_ready)
  );

  always #5 clk = ~clk;

  // Load through the cache; a miss is served by an SRAM that answers lat cycles after the request.
  task automatic rd(input logic [31:0] a, input logic [63:0] line, input int lat,
                    output logic m, output logic [31:0] d, output logic b, output logic f);
    @(negedge clk);
    address = a; rd_en = 1; #1;
    m = freeze; b = 0; f = 0; d = 0;
    if (!freeze) begin
      d = rdata;
      if (sram_rd_en || sram_wr_en) b = 1;
      @(negedge clk);
      rd_en = 0;
    end else begin
      for (int c = 0; c < lat; c++) begin
        if (!freeze || !sram_rd_en || sram_wr_en || sram_address !== (a & ~32'h4)) b = 1;
        @(negedge clk);
      end
      sram_rdata = line; sram_ready = 1; #1;
      d = rdata; f = freeze;
      @(negedge clk);
      sram_ready = 0; rd_en = 0;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic also_rd, input int lat,
                    output logic b, output logic f);
    @(negedge clk);
    address = a; wdata = wd; wr_en = 1; rd_en = also_rd; #1;
    b = 0;
    for (int c = 0; c < lat; c++) begin
      if (!freeze || !sram_wr_en || sram_rd_en || sram_address !== a || sram_wdata !== wd) b = 1;
      @(negedge clk);
    end
    sram_ready = 1; #1;
    f = freeze;
    @(negedge clk);
    sram_ready = 0; wr_en = 0; rd_en = 0;
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL rst_freeze got %b exp 0", freeze); end
    checks++; if (sram_rd_en !== 1'b0) begin errors++; $display("FAIL rst_sram_rd_en got %b exp 0", sram_rd_en); end
    checks++; if (sram_wr_en !== 1'b0) begin errors++; $display("FAIL rst_sram_wr_en got %b exp 0", sram_wr_en); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rdata); end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_miss_fill;
    rd(32'h000, 64'h22222222_11111111, 3, miss, data, bad, fz);
    checks++; if (miss !== 1'b1) begin errors++; $display("FAIL fill_miss got %b exp 1", miss); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL fill_stall_addr got %b exp 0", bad); end
    checks++; if (fz !== 1'b0) begin errors++; $display("FAIL fill_freeze_ready got %b exp 0", fz); end
    checks++; if (data !== 32'h11111111) begin errors++; $display("FAIL fill_bypass got %h exp 11111111", data); end
    rd(32'h004, 64'h0, 3, miss, data, bad, fz);
    checks++; if (miss !== 1'b0) begin errors++; $display("FAIL hit_odd_miss got %b exp 0", miss); end
    checks++; if (data !== 32'h22222222) begin errors++; $display("FAIL hit_odd_data got %h exp 22222222", data); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL hit_odd_sram got %b exp 0", bad); end
  endtask

  task automatic test_lru;
    rd(32'h200, 64'hbbbb0002_bbbb0001, 2, miss, data, bad, fz);
    checks++; if (miss !== 1'b1 || data !== 32'hbbbb0001) begin errors++; $display("FAIL lru_fill_b got %b/%h exp 1/bbbb0001", miss, data); end
    rd(32'h400, 64'hcccc0002_cccc0001, 4, miss, data, bad, fz);
    checks++; if (miss !== 1'b1 || data !== 32'hcccc0001) begin errors++; $display("FAIL lru_fill_c got %b/%h exp 1/cccc0001", miss, data); end
    rd(32'h200, 64'h0, 2, miss, data, bad, fz);
    checks++; if (miss !== 1'b0 || data !== 32'hbbbb0001) begin errors++; $display("FAIL lru_b_hit got %b/%h exp 0/bbbb0001", miss, data); end
    rd(32'h000, 64'h22222222_11111111, 2, miss, data, bad, fz);
    checks++; if (miss !== 1'b1 || data !== 32'h11111111) begin errors++; $display("FAIL lru_a_evicted got %b/%h exp 1/11111111", miss, data); end
    rd(32'h404, 64'h0, 2, miss, data, bad, fz);
    checks++; if (miss !== 1'b1) begin errors++; $display("FAIL lru_c_evicted got %b exp 1", miss); end
    rd(32'h000, 64'h22222222_11111111, 2, miss, data, bad, fz);
    rd(32'h200, 64'hbbbb0002_bbbb0001, 2, miss, data, bad, fz);
  endtask

  task automatic test_hit_refresh;
    rd(32'h008, 64'haaaa0002_aaaa0001, 2, miss, data, bad, fz);
    rd(32'h208, 64'hb1b10002_b1b10001, 3, miss, data, bad, fz);
    rd(32'h00c, 64'h0, 2, miss, data, bad, fz);
    checks++; if (miss !== 1'b0 || data !== 32'haaaa0002) begin errors++; $display("FAIL refresh_a_hit got %b/%h exp 0/aaaa0002", miss, data); end
    rd(32'h408, 64'hc1c10002_c1c10001, 2, miss, data, bad, fz);
    checks++; if (miss !== 1'b1) begin errors++; $display("FAIL refresh_c_miss got %b exp 1", miss); end
    rd(32'h008, 64'h0, 2, miss, data, bad, fz);
    checks++; if (miss !== 1'b0 || data !== 32'haaaa0001) begin errors++; $display("FAIL refresh_a_kept got %b/%h exp 0/aaaa0001", miss, data); end
    rd(32'h40c, 64'h0, 2, miss, data, bad, fz);
    checks++; if (miss !== 1'b0 || data !== 32'hc1c10002) begin errors++; $display("FAIL refresh_c_hit got %b/%h exp 0/c1c10002", miss, data); end
    rd(32'h208, 64'hb1b10002_b1b10001, 2, miss, data, bad, fz);
    checks++; if (miss !== 1'b1) begin errors++; $display("FAIL refresh_b_evicted got %b exp 1", miss); end
  endtask

  task automatic test_write_hit;
    wr(32'h004, 32'hdeadbeef, 1'b0, 3, bad, fz);
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL wr_hit_stall got %b exp 0", bad); end
    checks++; if (fz !== 1'b0) begin errors++; $display("FAIL wr_hit_freeze_ready got %b exp 0", fz); end
    rd(32'h004, 64'h0, 2, miss, data, bad, fz);
    checks++; if (miss !== 1'b0 || data !== 32'hdeadbeef) begin errors++; $display("FAIL wr_hit_readback got %b/%h exp 0/deadbeef", miss, data); end
    rd(32'h000, 64'h0, 2, miss, data, bad, fz);
    checks++; if (miss !== 1'b0 || data !== 32'h11111111) begin errors++; $display("FAIL wr_hit_other_word got %b/%h exp 0/11111111", miss, data); end
    rd(32'h204, 64'h0, 2, miss, data, bad, fz);
    checks++; if (miss !== 1'b0 || data !== 32'hbbbb0002) begin errors++; $display("FAIL wr_hit_other_way got %b/%h exp 0/bbbb0002", miss, data); end
  endtask

  task automatic test_write_miss;
    wr(32'h800, 32'h12345678, 1'b1, 2, bad, fz);
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL wr_miss_stall_prio got %b exp 0", bad); end
    rd(32'h800, 64'h55550002_55550001, 2, miss, data, bad, fz);
    checks++; if (miss !== 1'b1 || data !== 32'h55550001) begin errors++; $display("FAIL wr_miss_no_alloc got %b/%h exp 1/55550001", miss, data); end
    @(negedge clk); #1;
    checks++; if (rdata !== 32'h0 || freeze !== 1'b0) begin errors++; $display("FAIL idle_outputs got %h/%b exp 0/0", rdata, freeze); end
  endtask

  task automatic test_reset_rmiss;
    @(negedge clk);
    address = 32'h600; rd_en = 1; #1;
    checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL rr_req_freeze got %b exp 1", freeze); end
    @(negedge clk); #1;
    checks++; if (sram_rd_en !== 1'b1 || freeze !== 1'b1) begin errors++; $display("FAIL rr_rmiss got %b/%b exp 1/1", sram_rd_en, freeze); end
    @(negedge clk);
    rst = 0; rd_en = 0; #1;
    checks++; if (freeze !== 1'b0 || sram_rd_en !== 1'b0 || sram_wr_en !== 1'b0) begin errors++; $display("FAIL rr_abort got %b/%b/%b exp 0/0/0", freeze, sram_rd_en, sram_wr_en); end
    sram_rdata = 64'h66660002_66660001; sram_ready = 1;
    @(negedge clk);
    sram_ready = 0; rst = 1;
    rd(32'h600, 64'h77770002_77770001, 2, miss, data, bad, fz);
    checks++; if (miss !== 1'b1 || data !== 32'h77770001) begin errors++; $display("FAIL rr_no_stale got %b/%h exp 1/77770001", miss, data); end
    rd(32'h000, 64'h22222222_11111111, 2, miss, data, bad, fz);
    checks++; if (miss !== 1'b1) begin errors++; $display("FAIL rr_valid_cleared got %b exp 1", miss); end
  endtask

  initial begin
    test_reset;
    test_miss_fill;
    test_lru;
    test_hit_refresh;
    test_write_hit;
    test_write_miss;
    test_reset_rmiss;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
